sv_uart_rx_packer: RTL and testbench

- Byte-to-word assembler directly downstream of the UART engine's 8-bit receive AXI-Stream output.
- Packs WORDS_NUM consecutive received bytes, MSB byte first, into one DATA_WIDTH word. This matches the order in which the engine transmits a word.
- An inter-byte silence timeout, measured in UART character times, discards a partial word so a lost byte cannot misalign every following word.
- Output is a registered AXI-Stream word towards user logic.

---
 rtl/sv_uart_pkg.sv | 11 +
 rtl/sv_uart_rx_packer_if.sv | 26 ++
 rtl/sv_uart_timeout.sv | 26 ++
 rtl/sv_uart_rx_packer.sv | 88 ++++++++
 tb/tb_sv_uart_rx_packer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/sv_uart_pkg.sv
// Shared UART constants and helpers, common to the RX packer and the UART engine.
package sv_uart_pkg;

  localparam int WORD_WIDTH    = 8;
  localparam int BITS_PER_CHAR = 10;

  function automatic int words_num(input int data_width);
    return data_width / WORD_WIDTH;
  endfunction

endpackage

// File: rtl/sv_uart_rx_packer_if.sv
// Stream bundle for the RX packer: byte stream in from the engine, word stream out to user logic.
interface sv_uart_rx_packer_if #(
  parameter int DATA_WIDTH = 24
);
  import sv_uart_pkg::*;

  logic [WORD_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  // Environment side: supplies bytes, consumes words.
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  // Packer side.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

endinterface

// File: rtl/sv_uart_timeout.sv
// Character-time silence counter: counts while enabled, pulses expire once the limit is reached.
module sv_uart_timeout (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic        expire
);

  logic [31:0] count;

  // >= keeps a shrinking limit from being skipped over when the divider changes mid-count.
  assign expire = enable && (limit != 32'd0) && (count >= limit - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (restart || !enable || expire) begin
      count <= 32'd0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/sv_uart_rx_packer.sv
// Packs received UART bytes (MSB byte first) into DATA_WIDTH words, dropping partial words after silence.
// Optional drop counter port odrop_cnt is enabled by defining SV_UART_RX_PACKER_STAT_EN.
module sv_uart_rx_packer
  import sv_uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 24,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic        iclk,
  input  logic        irst,
  sv_uart_rx_packer_if.slave bus,
  input  logic [15:0] idivider,
`ifdef SV_UART_RX_PACKER_STAT_EN
  output logic [15:0] odrop_cnt,
`endif
  output logic        oflush
);

  localparam int WORDS_NUM = words_num(DATA_WIDTH);
  localparam int CNT_W     = $clog2(WORDS_NUM);
  localparam int SREG_W    = DATA_WIDTH - WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_NUM - 1);

  typedef logic [SREG_W-1:0] sreg_t;

  logic [CNT_W-1:0] cnt;
  sreg_t            sreg;
  logic             accept;
  logic             expire;
  logic [31:0]      limit;

  // The completing byte is the only one that waits for the output register to drain.
  assign bus.s_axis_tready = ~bus.m_axis_tvalid | (cnt != LAST);
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;

  assign limit = (TIMEOUT_CHARS == 0) ? 32'd0
               : 32'(idivider) * 32'(BITS_PER_CHAR * TIMEOUT_CHARS);

  sv_uart_timeout u_timeout (
    .clk     (iclk),
    .rst     (irst),
    .restart (accept),
    .enable  (cnt != '0),
    .limit   (limit),
    .expire  (expire)
  );

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt               <= '0;
      sreg              <= '0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tvalid <= 1'b0;
      oflush            <= 1'b0;
    end else begin
      oflush <= 1'b0;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        bus.m_axis_tvalid <= 1'b0;
      end
      // An accepted byte takes priority over a coincident timeout expiry.
      if (accept) begin
        sreg <= sreg_t'({sreg, bus.s_axis_tdata});
        if (cnt == LAST) begin
          bus.m_axis_tdata  <= {sreg, bus.s_axis_tdata};
          bus.m_axis_tvalid <= 1'b1;
          cnt               <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (expire) begin
        cnt    <= '0;
        sreg   <= '0;
        oflush <= 1'b1;
      end
    end
  end

`ifdef SV_UART_RX_PACKER_STAT_EN
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      odrop_cnt <= 16'd0;
    end else if (oflush && (odrop_cnt != 16'hFFFF)) begin
      odrop_cnt <= odrop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sv_uart_rx_packer.sv
// Directed self-checking bench for sv_uart_rx_packer (DATA_WIDTH=24, TIMEOUT_CHARS=4).
module tb_sv_uart_rx_packer;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic [15:0] idivider = 16'd4;
  logic        oflush;
`ifdef SV_UART_RX_PACKER_STAT_EN
  logic [15:0] odrop_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  sv_uart_rx_packer_if #(.DATA_WIDTH(24)) bus ();

  sv_uart_rx_packer #(.DATA_WIDTH(24), .TIMEOUT_CHARS(4)) dut (
    .iclk     (iclk),
    .irst     (irst),
    .bus      (bus),
    .idivider (idivider),
`ifdef SV_UART_RX_PACKER_STAT_EN
    .odrop_cnt(odrop_cnt),
`endif
    .oflush   (oflush)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iclk);
      #1;
    end
  endtask

  // Offer one byte and wait (bounded) for it to be accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    bit ok;
    bit rdy;
    ok = 1'b0;
    bus.s_axis_tdata  = b;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = bus.s_axis_tready;
      @(posedge iclk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    chk("byte_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    bit seen_flush;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;

    // Reset state
    #2;
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(bus.m_axis_tdata),  32'd0);
    chk("rst_flush",  32'(oflush),            32'd0);
    chk("rst_sready", 32'(bus.s_axis_tready), 32'd1);
    tick(2);
    irst = 1'b0;
    tick(1);

    // Back-to-back word
    send(8'hA1); send(8'hB2); send(8'hC3);
    chk("w1_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("w1_tdata",  32'(bus.m_axis_tdata),  32'hA1B2C3);
    tick(1);
    chk("w1_one_cycle", 32'(bus.m_axis_tvalid), 32'd0);

    // Backpressure: collection continues, completing byte stalls
    bus.m_axis_tready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03);
    chk("w2_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("w2_tdata",  32'(bus.m_axis_tdata),  32'h010203);
    send(8'h04); send(8'h05);
    bus.s_axis_tdata  = 8'h06;
    bus.s_axis_tvalid = 1'b1;
    #1;
    chk("w2_stall", 32'(bus.s_axis_tready), 32'd0);
    tick(5);
    chk("w2_hold_data",  32'(bus.m_axis_tdata),  32'h010203);
    chk("w2_hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("w2_still_stall", 32'(bus.s_axis_tready), 32'd0);
    bus.m_axis_tready = 1'b1;
    #1;
    chk("w2_no_comb_path", 32'(bus.s_axis_tready), 32'd0);
    tick(1);
    bus.m_axis_tready = 1'b0;
    chk("w2_drained", 32'(bus.m_axis_tvalid), 32'd0);
    chk("w2_ready_again", 32'(bus.s_axis_tready), 32'd1);
    tick(1);
    bus.s_axis_tvalid = 1'b0;
    chk("w3_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("w3_tdata",  32'(bus.m_axis_tdata),  32'h040506);
    bus.m_axis_tready = 1'b1;
    tick(1);

    // Timeout drops a partial word (L = 4*10*4 = 160)
    send(8'h11); send(8'h22);
    tick(159);
    chk("to_not_yet", 32'(oflush), 32'd0);
    tick(1);
    chk("to_flush", 32'(oflush), 32'd1);
    tick(1);
    chk("to_pulse_end", 32'(oflush), 32'd0);
    send(8'h33); send(8'h44); send(8'h55);
    chk("to_word", 32'(bus.m_axis_tdata), 32'h334455);
    chk("to_valid", 32'(bus.m_axis_tvalid), 32'd1);
    tick(1);

    // Byte arriving on the expiry cycle wins
    send(8'h66);
    tick(159);
    send(8'h77);
    chk("exp_race_flush", 32'(oflush), 32'd0);
    tick(1);
    chk("exp_race_flush2", 32'(oflush), 32'd0);
    send(8'h88);
    chk("exp_race_word", 32'(bus.m_axis_tdata), 32'h667788);
    tick(1);

    // Async reset mid-word with a pending output word
    bus.m_axis_tready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03);
    send(8'h04); send(8'h05);
    #2;
    irst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("arst_tdata",  32'(bus.m_axis_tdata),  32'd0);
    chk("arst_sready", 32'(bus.s_axis_tready), 32'd1);
    #1;
    irst = 1'b0;
    bus.m_axis_tready = 1'b1;
    tick(1);
    send(8'h09); send(8'h0A); send(8'h0B);
    chk("arst_word", 32'(bus.m_axis_tdata), 32'h090A0B);
    tick(1);

    // idivider = 0 disables the timeout
    idivider = 16'd0;
    send(8'h12);
    seen_flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (oflush) seen_flush = 1'b1;
    end
    chk("div0_no_flush", 32'(seen_flush), 32'd0);
    send(8'h34); send(8'h56);
    chk("div0_word", 32'(bus.m_axis_tdata), 32'h123456);
    tick(1);

`ifdef SV_UART_RX_PACKER_STAT_EN
    // Three forced timeouts (L = 40) since the last reset
    chk("stat_zero", 32'(odrop_cnt), 32'd0);
    idivider = 16'd1;
    for (int k = 0; k < 3; k++) begin
      send(8'hE0);
      tick(50);
    end
    chk("stat_three", 32'(odrop_cnt), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
